// File: rtl/fp_cmp_seq.sv
// Request sequencer in front of the FP compare core: resolves NaN, signed-zero
// and reserved-op requests locally, issues the rest and applies IEEE fix-ups.
module fp_cmp_seq #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              cmp_start,
  output logic [1:0]        cmp_fn,
  output logic [DATA_W-1:0] cmp_op_a,
  output logic [DATA_W-1:0] cmp_op_b,
  input  logic              cmp_done,
  input  logic              cmp_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_res,
  output logic              rsp_nv,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
);
  localparam int MAN_W = DATA_W - EXP_W - 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FEQ = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]       state;
  logic [CNT_W-1:0] to_cnt;

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (&x[DATA_W-2 -: EXP_W]) && (x[MAN_W-1:0] != '0);
  endfunction

  function automatic logic is_snan(input logic [DATA_W-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  logic a_nan, b_nan, any_snan, both_zero;
  logic local_hit, loc_res, loc_nv, loc_err;

  always_comb begin
    a_nan     = is_nan(req_a);
    b_nan     = is_nan(req_b);
    any_snan  = is_snan(req_a) || is_snan(req_b);
    both_zero = (req_a[DATA_W-2:0] == '0) && (req_b[DATA_W-2:0] == '0);
    local_hit = 1'b1;
    loc_res   = 1'b0;
    loc_nv    = 1'b0;
    loc_err   = 1'b0;
    if (req_op == OP_RSV)
      loc_err = 1'b1;
    else if (a_nan || b_nan)
      loc_nv = (req_op == OP_FEQ) ? any_snan : 1'b1;
    else if (both_zero)
      loc_res = (req_op != OP_FLT);
    else
      local_hit = 1'b0;
  end

  assign req_ready = (state == IDLE);
  assign cmp_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      to_cnt   <= '0;
      cmp_fn   <= 2'b00;
      cmp_op_a <= '0;
      cmp_op_b <= '0;
      rsp_res  <= 1'b0;
      rsp_nv   <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          // request op encoding doubles as the core function code
          cmp_fn   <= req_op;
          cmp_op_a <= req_a;
          cmp_op_b <= req_b;
          rsp_tag  <= req_tag;
          if (local_hit) begin
            state   <= RESP;
            rsp_res <= loc_res;
            rsp_nv  <= loc_nv;
            rsp_err <= loc_err;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          to_cnt <= '0;
        end
        WAIT: if (cmp_done) begin
          state   <= RESP;
          // core "less" includes equality; identical operands are never FLT
          rsp_res <= (cmp_fn == OP_FLT) ? (cmp_res & (cmp_op_a != cmp_op_b)) : cmp_res;
          rsp_nv  <= 1'b0;
          rsp_err <= 1'b0;
        end else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
          // this idle cycle would bring the count to TIMEOUT
          state   <= RESP;
          rsp_res <= 1'b0;
          rsp_nv  <= 1'b0;
          rsp_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_cmp_seq.md
# fp_cmp_seq

Request sequencer placed directly upstream of the floating-point compare core. It accepts FEQ/FLT/FLE requests over a valid/ready handshake and handles NaN and signed-zero cases locally. All other requests are issued to the compare core as a one-cycle `start` pulse. The block waits for `done` (with a timeout), applies IEEE-754 corrections and the invalid-operation (NV) flag, and holds the tagged result until the consumer accepts it.

## Interface
- `DATA_W`, 32: operand width.
- `EXP_W`, 8: exponent width; mantissa width is `DATA_W-EXP_W-1`.
- `TAG_W`, 4: request tag width.
- `TIMEOUT`, 15: maximum number of WAIT cycles before abort (4-bit counter).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; equals state==IDLE.
- `req_op` in 2: 00 FLE, 01 FLT, 10 FEQ, 11 reserved.
- `req_a`, `req_b` in DATA_W: operands.
- `req_tag` in TAG_W: returned unchanged with the response.
- `cmp_start` out 1: one-cycle start pulse to the core.
- `cmp_fn` out 2: core function; 10 = equal, 01 = less, 00 = less-or-equal.
- `cmp_op_a`, `cmp_op_b` out DATA_W: latched operands to the core.
- `cmp_done` in 1: core completion.
- `cmp_res` in 1: core result; valid when `cmp_done` is high.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_res` out 1: compare result.
- `rsp_nv` out 1: invalid-operation flag.
- `rsp_err` out 1: reserved op or timeout.
- `rsp_tag` out TAG_W: tag of the request.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **Accept:** a request is accepted when `req_valid & req_ready`. On accept, latch op, a, b and tag, then classify:
  - NaN: exponent all ones and mantissa ≠ 0.
  - sNaN: NaN with mantissa MSB = 0.
  - Zero: bits `[DATA_W-2:0]` = 0.
- **Local path (IDLE→RESP, core not used):**
  - Reserved op: res 0, nv 0, err 1.
  - Either operand NaN: res 0. nv = 1 for FLT/FLE. For FEQ, nv = 1 only if either operand is sNaN.
  - Both operands zero, any sign: FEQ 1, FLE 1, FLT 0; nv 0.
- **Core path:** IDLE→ISSUE→WAIT.
  - ISSUE: `cmp_start`=1 for exactly one cycle, with `cmp_fn` = 10 for FEQ, 01 for FLT, 00 for FLE.
  - `cmp_op_a`/`cmp_op_b`/`cmp_fn` stay stable from ISSUE until the block leaves WAIT.
- **WAIT on `cmp_done`:** go to RESP with:
  - FEQ: res = `cmp_res`.
  - FLE: res = `cmp_res`.
  - FLT: res = `cmp_res & (a != b)`. The core's less output is inclusive of equality for positive operands, so the block masks it.
  - nv 0, err 0.
- **Timeout:** a counter clears on entry to WAIT and increments each WAIT cycle without `cmp_done`. When it reaches `TIMEOUT`, go to RESP with res 0, nv 0, err 1.
- **Ignored `cmp_done`:** any `cmp_done` in IDLE, ISSUE or RESP is ignored, including a late `done` after a timeout.
- **RESP:** hold `rsp_*` stable while `rsp_valid`=1. On `rsp_ready`, go to IDLE and clear `rsp_valid`.
- No new request is accepted in the same cycle the response is consumed.

## Timing
- Reset values:
  - Outputs: `req_ready` 1 (state IDLE); `cmp_start`, `cmp_fn`, `cmp_op_a`, `cmp_op_b` all 0; `rsp_valid`, `rsp_res`, `rsp_nv`, `rsp_err`, `rsp_tag` all 0.
  - Internal: counter 0.
- Core path (1-cycle core), with accept at cycle 0:
  - `cmp_start` high in cycle 1.
  - `cmp_done` in cycle 2.
  - `rsp_valid` high from cycle 3.
  - Request-to-response latency is 3 cycles.
- Local path: accept at cycle 0, `rsp_valid` from cycle 1.
- Throughput: one request per (latency + 1) cycles when `rsp_ready` is tied high.
- Timeout: `rsp_valid` rises in cycle 2+TIMEOUT after accept if `done` never arrives.
- Reset mid-operation: return to IDLE immediately. Any pending response is discarded and `cmp_start` is low in the next cycle.
- `req_valid` while not IDLE: the request is not accepted. The requester holds it; the block does not latch it.

## Test plan
- FLT a=0x3F800000 (1.0), b=0x40000000 (2.0) -> `cmp_start` in cycle 1 with `cmp_fn`=01; rsp res 1, nv 0, err 0, `rsp_valid` in cycle 3. FLT a=b=0x3F800000 -> res 0 even though the core returns 1.
- FEQ a=0x00000000, b=0x80000000 -> no `cmp_start`; rsp in cycle 1 with res 1, nv 0. FLT on the same pair -> res 0.
- FEQ a=0x7FC00000 (qNaN), b=0x3F800000 -> res 0, nv 0. FEQ a=0x7F800001 (sNaN) -> res 0, nv 1. FLE a=0x7FC00000 -> res 0, nv 1.
- FLE a=0xC0000000, b=0xBF800000 with the core stubbed to never assert `done` (TIMEOUT=15) -> rsp res 0, err 1 in cycle 17. A later `cmp_done` pulse is ignored.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_*` stable and `req_ready`=0 throughout. A second request is accepted only after the handshake and is returned with its own tag (0x3 then 0xA).
- Reset asserted in WAIT -> all outputs at reset values. A `cmp_done` in the cycle after reset release produces no response. req_op=11 -> rsp err 1 in cycle 1.
